// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control FSM:
// state enum, opcode values, datapath mux encodings and the control vector.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
   } state_t;

   localparam int unsigned OP_R    = 0;
   localparam int unsigned OP_J    = 2;
   localparam int unsigned OP_BEQ  = 4;
   localparam int unsigned OP_BNE  = 5;
   localparam int unsigned OP_ADDI = 8;
   localparam int unsigned OP_LW   = 35;
   localparam int unsigned OP_SW   = 43;

   typedef enum logic [1:0] {
      SRCB_RT = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
   } alusrcb_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10
   } aluop_t;

   typedef enum logic [1:0] {
      PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10
   } pcsource_t;

   typedef struct packed {
      logic      pcwrite;
      logic      pcwritecond;
      logic      bne;
      logic      iord;
      logic      memread;
      logic      memwrite;
      logic      irwrite;
      logic      regdst;
      logic      memtoreg;
      logic      regwrite;
      logic      alusrca;
      alusrcb_t  alusrcb;
      aluop_t    aluop;
      pcsource_t pcsource;
      logic      illegal_op;
   } ctrl_t;

   function automatic logic op_supported(input logic [31:0] op);
      return op inside {OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
   endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational control-vector decoder: current state (plus mem_ready for the
// Mealy fetch strobes and opcode for bne/illegal_op) to datapath controls.
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPW = 6
) (
   input  state_t           state,
   input  logic             mem_ready,
   input  logic [OPW-1:0]   opcode,
   output ctrl_t            ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.memread = 1'b1;
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            ctrl.alusrcb    = SRCB_IMM_SH2;
            ctrl.illegal_op = !op_supported(32'(opcode));
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.memwrite = 1'b1;
            ctrl.iord     = 1'b1;
         end
         S_EXEC: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alusrca     = 1'b1;
            ctrl.aluop       = ALU_SUB;
            ctrl.pcwritecond = 1'b1;
            ctrl.pcsource    = PC_ALUOUT;
            ctrl.bne         = (opcode == OPW'(OP_BNE));
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_JUMP: begin
            ctrl.pcwrite  = 1'b1;
            ctrl.pcsource = PC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter; per-state controls come from mips_ctrl_outdec.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned OPW  = 6,
   parameter int unsigned CNTW = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPW-1:0]   opcode,
   input  logic             mem_ready,
   output logic             pcwrite,
   output logic             pcwritecond,
   output logic             bne,
   output logic             iord,
   output logic             memread,
   output logic             memwrite,
   output logic             irwrite,
   output logic             regdst,
   output logic             memtoreg,
   output logic             regwrite,
   output logic             alusrca,
   output logic [1:0]       alusrcb,
   output logic [1:0]       aluop,
   output logic [1:0]       pcsource,
   output logic             illegal_op,
   output logic [CNTW-1:0]  instret
);

   state_t state_q, state_d;
   logic   retire;
   logic   mem_is_sw_q;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RST;
      else        state_q <= state_d;
   end

   // opcode is only looked at in DECODE, so remember lw/sw for MEMADR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  mem_is_sw_q <= 1'b0;
      else if (state_q == S_DECODE) mem_is_sw_q <= (opcode == OPW'(OP_SW));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + 1'b1;
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_RST:   state_d = S_FETCH;
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            if (opcode == OPW'(OP_R))
               state_d = S_EXEC;
            else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW))
               state_d = S_MEMADR;
            else if (opcode == OPW'(OP_BEQ) || opcode == OPW'(OP_BNE))
               state_d = S_BRANCH;
            else if (opcode == OPW'(OP_ADDI))
               state_d = S_ADDIEX;
            else if (opcode == OPW'(OP_J))
               state_d = S_JUMP;
            else
               state_d = S_FETCH;
         end
         S_MEMADR:  state_d = mem_is_sw_q ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: if (mem_ready) state_d = S_MEMWB;
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end
         end
         S_EXEC:   state_d = S_ALUWB;
         S_ADDIEX: state_d = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: state_d = S_RST;
      endcase
   end

   mips_ctrl_outdec #(.OPW(OPW)) u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .opcode    (opcode),
      .ctrl      (ctrl)
   );

   assign pcwrite     = ctrl.pcwrite;
   assign pcwritecond = ctrl.pcwritecond;
   assign bne         = ctrl.bne;
   assign iord        = ctrl.iord;
   assign memread     = ctrl.memread;
   assign memwrite    = ctrl.memwrite;
   assign irwrite     = ctrl.irwrite;
   assign regdst      = ctrl.regdst;
   assign memtoreg    = ctrl.memtoreg;
   assign regwrite    = ctrl.regwrite;
   assign alusrca     = ctrl.alusrca;
   assign alusrcb     = ctrl.alusrcb;
   assign aluop       = ctrl.aluop;
   assign pcsource    = ctrl.pcsource;
   assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench: each instruction is expanded into its expected per-cycle
// control vectors; a negedge monitor pops and compares against the DUT.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, bne, iord, memread, memwrite, irwrite;
   logic       regdst, memtoreg, regwrite, alusrca, illegal_op;
   logic [1:0] alusrcb, aluop, pcsource;
   logic [3:0] instret;

   mips_multicycle_ctrl #(.OPW(6), .CNTW(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pcwrite(pcwrite), .pcwritecond(pcwritecond), .bne(bne), .iord(iord),
      .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
      .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
      .pcsource(pcsource), .illegal_op(illegal_op), .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [17:0] obs;
   assign obs = {pcwrite, pcwritecond, bne, iord, memread, memwrite, irwrite,
                 regdst, memtoreg, regwrite, alusrca, alusrcb, aluop, pcsource,
                 illegal_op};

   localparam logic [10:0] F_PCW  = 11'b10000000000;
   localparam logic [10:0] F_PCWC = 11'b01000000000;
   localparam logic [10:0] F_BNE  = 11'b00100000000;
   localparam logic [10:0] F_IORD = 11'b00010000000;
   localparam logic [10:0] F_MRD  = 11'b00001000000;
   localparam logic [10:0] F_MWR  = 11'b00000100000;
   localparam logic [10:0] F_IRW  = 11'b00000010000;
   localparam logic [10:0] F_RDST = 11'b00000001000;
   localparam logic [10:0] F_M2R  = 11'b00000000100;
   localparam logic [10:0] F_RW   = 11'b00000000010;
   localparam logic [10:0] F_SRCA = 11'b00000000001;
   localparam logic [10:0] F_NONE = 11'b00000000000;

   function automatic logic [17:0] mk(input logic [10:0] fl, input logic [1:0] srcb,
                                      input logic [1:0] op, input logic [1:0] pcs,
                                      input logic ill);
      return {fl, srcb, op, pcs, ill};
   endfunction

   logic [17:0] q[$];
   logic [3:0]  cq[$];
   string       nq[$];
   logic [3:0]  cnt;
   int          checks;
   int          failures;

   initial begin
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            logic [17:0] ev;
            logic [3:0]  ec;
            string       en;
            ev = q.pop_front();
            ec = cq.pop_front();
            en = nq.pop_front();
            checks++;
            if (obs !== ev || instret !== ec) begin
               failures++;
               $display("FAIL %s: ctrl=%h instret=%0d expected ctrl=%h instret=%0d",
                        en, obs, instret, ev, ec);
            end
         end
      end
   end

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic cycle(input logic [5:0] op, input logic mr, input logic [17:0] v,
                        input string nm);
      @(posedge clk);
      #1;
      opcode    = op;
      mem_ready = mr;
      q.push_back(v);
      cq.push_back(cnt);
      nq.push_back(nm);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt   = '0;
      q.push_back('0);
      cq.push_back(cnt);
      nq.push_back("rst_state");
   endtask

   task automatic fetch_decode(input logic [5:0] op, input int unsigned fw,
                               input logic ill);
      for (int unsigned i = 0; i < fw; i++)
         cycle(op, 1'b0, mk(F_MRD, 2'b01, 2'b00, 2'b00, 1'b0), "fetch_wait");
      cycle(op, 1'b1, mk(F_MRD | F_IRW | F_PCW, 2'b01, 2'b00, 2'b00, 1'b0), "fetch");
      cycle(op, rnd(), mk(F_NONE, 2'b11, 2'b00, 2'b00, ill), "decode");
   endtask

   task automatic run_instr(input logic [5:0] op, input int unsigned fw,
                            input int unsigned mw);
      logic ill;
      ill = !(op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43});
      fetch_decode(op, fw, ill);
      if (ill) return;
      case (op)
         6'd0: begin
            cycle(op, rnd(), mk(F_SRCA, 2'b00, 2'b10, 2'b00, 1'b0), "exec");
            cycle(op, rnd(), mk(F_RW | F_RDST, 2'b00, 2'b00, 2'b00, 1'b0), "aluwb");
         end
         6'd35: begin
            cycle(op, rnd(), mk(F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0), "lw_memadr");
            for (int unsigned i = 0; i < mw; i++)
               cycle(op, 1'b0, mk(F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0), "memread_wait");
            cycle(op, 1'b1, mk(F_MRD | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0), "memread");
            cycle(op, rnd(), mk(F_RW | F_M2R, 2'b00, 2'b00, 2'b00, 1'b0), "memwb");
         end
         6'd43: begin
            cycle(op, rnd(), mk(F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0), "sw_memadr");
            for (int unsigned i = 0; i < mw; i++)
               cycle(op, 1'b0, mk(F_MWR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0), "memwrite_wait");
            cycle(op, 1'b1, mk(F_MWR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0), "memwrite");
         end
         6'd4, 6'd5: begin
            cycle(op, rnd(), mk(F_SRCA | F_PCWC | ((op == 6'd5) ? F_BNE : F_NONE),
                                2'b00, 2'b01, 2'b01, 1'b0), "branch");
         end
         6'd8: begin
            cycle(op, rnd(), mk(F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0), "addiex");
            cycle(op, rnd(), mk(F_RW, 2'b00, 2'b00, 2'b00, 1'b0), "addiwb");
         end
         default: begin
            cycle(op, rnd(), mk(F_PCW, 2'b00, 2'b00, 2'b10, 1'b0), "jump");
         end
      endcase
      cnt = cnt + 4'd1;
   endtask

   // sw interrupted by reset while the write is still waiting on memory
   task automatic sw_abort(input int unsigned fw);
      fetch_decode(6'd43, fw, 1'b0);
      cycle(6'd43, rnd(), mk(F_SRCA, 2'b10, 2'b00, 2'b00, 1'b0), "sw_memadr");
      cycle(6'd43, 1'b0, mk(F_MWR | F_IORD, 2'b00, 2'b00, 2'b00, 1'b0), "abort_memwrite_wait");
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (memwrite !== 1'b0 || obs !== '0 || instret !== 4'd0) begin
         failures++;
         $display("FAIL async_reset: memwrite=%b ctrl=%h instret=%0d expected memwrite=0 ctrl=0 instret=0",
                  memwrite, obs, instret);
      end
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   logic [5:0] ops [10];

   initial begin
      checks    = 0;
      failures  = 0;
      cnt       = '0;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      opcode    = '0;
      ops = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43, 6'd63, 6'd1, 6'd12};
      #2;
      checks++;
      if (obs !== '0 || instret !== 4'd0) begin
         failures++;
         $display("FAIL reset_outputs: ctrl=%h instret=%0d expected ctrl=0 instret=0", obs, instret);
      end
      repeat (2) @(posedge clk);
      release_reset();

      run_instr(6'd0, 0, 0);
      run_instr(6'd35, 0, 2);
      run_instr(6'd5, 0, 0);
      run_instr(6'd4, 1, 0);
      run_instr(6'd63, 0, 0);
      run_instr(6'd8, 2, 0);
      run_instr(6'd43, 0, 1);
      sw_abort(1);

      for (int i = 0; i < 17; i++) run_instr(6'd2, 0, 0);

      for (int i = 0; i < 60; i++)
         run_instr(ops[$urandom_range(0, 9)], $urandom_range(0, 2), $urandom_range(0, 2));

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: pending=%0d expected pending=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

- Moore/Mealy control FSM that sequences a multicycle version of the single-cycle MIPS datapath.
- The datapath has one shared instruction/data memory, an IR, and ALUOut/MDR registers.
- The FSM issues per-state datapath controls and stalls on a memory-ready handshake.
- It counts retired instructions and sits beside the datapath, taking its opcode from the IR.

## Interface
- `OPW`, default 6: opcode width.
- `CNTW`, default 32: retired-instruction counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  OPW  IR[31:26]; stable from end of FETCH until next FETCH.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pcwrite`  out  1  unconditional PC load.
- `pcwritecond`  out  1  conditional PC load; datapath loads if `zero ^ bne`.
- `bne`  out  1  inverts branch condition.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memread`  out  1  memory read strobe.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  IR load.
- `regdst`  out  1  1 = rd, 0 = rt.
- `memtoreg`  out  1  1 = MDR, 0 = ALUOut.
- `regwrite`  out  1  register-file write.
- `alusrca`  out  1  0 = PC, 1 = rs data.
- `alusrcb`  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `aluop`  out  2  00 = add, 01 = sub, 10 = funct.
- `pcsource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- `instret`  out  CNTW  retired-instruction count.

## Operation
- States: RST, FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Every output not listed for a state is 0.
- **RST**: all outputs 0; goes to FETCH on the first clock after `rst_n` rises.
- **FETCH**:
  - `memread`=1, `iord`=0, `alusrca`=0, `alusrcb`=01, `aluop`=00, `pcsource`=00.
  - `irwrite` = `pcwrite` = `mem_ready` (Mealy).
  - Holds until `mem_ready`, then goes to DECODE.
- **DECODE**: `alusrca`=0, `alusrcb`=11, `aluop`=00 (branch target into ALUOut). Next state by opcode:
  - 0 → EXEC
  - 35 or 43 → MEMADR
  - 4 or 5 → BRANCH
  - 8 → ADDIEX
  - 2 → JUMP
  - other → FETCH with `illegal_op`=1 (not retired).
- **MEMADR**: `alusrca`=1, `alusrcb`=10, `aluop`=00; lw → MEMREAD, sw → MEMWRITE.
- **MEMREAD**: `memread`=1, `iord`=1; holds until `mem_ready`, then MEMWB.
- **MEMWB**: `regwrite`=1, `memtoreg`=1, `regdst`=0; then FETCH.
- **MEMWRITE**: `memwrite`=1, `iord`=1; held high until `mem_ready`, then FETCH.
- **EXEC**: `alusrca`=1, `alusrcb`=00, `aluop`=10; then ALUWB.
- **ALUWB**: `regwrite`=1, `regdst`=1, `memtoreg`=0; then FETCH.
- **BRANCH**: `alusrca`=1, `alusrcb`=00, `aluop`=01, `pcwritecond`=1, `pcsource`=01, `bne`=(opcode==5); then FETCH.
- **ADDIEX**: `alusrca`=1, `alusrcb`=10, `aluop`=00; then ADDIWB.
- **ADDIWB**: `regwrite`=1, `regdst`=0, `memtoreg`=0; then FETCH.
- **JUMP**: `pcwrite`=1, `pcsource`=10; then FETCH.
- `instret` increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB or JUMP. It wraps modulo 2^CNTW.

## Timing
- Minimum cycles per instruction with `mem_ready` held high:
  - 5: lw.
  - 4: R-type, sw, addi.
  - 3: beq, bne, j.
- Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Strobes stay asserted and no other output changes.
- `mem_ready` is ignored in all other states.
- State register updates on the rising `clk` edge only.
- `rst_n` low asserts asynchronously at any point, including mid-instruction or during a memory wait:
  - state → RST immediately.
  - all outputs 0 immediately.
  - `instret` → 0.
  - No partial write completes after reset asserts.
- `opcode` is sampled only in DECODE and BRANCH.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum;
  - opcode constants: R=0, J=2, BEQ=4, BNE=5, ADDI=8, LW=35, SW=43;
  - `alusrcb`, `aluop` and `pcsource` encodings.
- Sub-module `mips_ctrl_outdec`: combinational state (+`mem_ready`, `opcode`) → control-vector decoder.
- The top level holds the state register, next-state logic and `instret`.

## Test plan
- Reset, then `mem_ready`=1 and opcode=0 → states RST, FETCH, DECODE, EXEC, ALUWB, FETCH; `regwrite`=1 and `regdst`=1 only in ALUWB; `instret`=1.
- opcode=35, `mem_ready` low for 2 cycles in MEMREAD → lw takes 7 cycles; `memread`=`iord`=1 held throughout the stall; `instret`+1.
- opcode=5 → BRANCH with `pcwritecond`=1, `bne`=1, `pcsource`=01, `aluop`=01; opcode=4 gives `bne`=0.
- opcode=63 → `illegal_op` pulses 1 cycle in DECODE; next state FETCH; `instret` unchanged.
- sw with `rst_n` dropped while `memwrite`=1 and `mem_ready`=0 → `memwrite` falls without a clock edge; state RST; `instret`=0.
- Preload `instret`=2^CNTW-1 (CNTW=4: 15), retire one j → `instret`=0.
